// File: rtl/xbar_pkg.sv
// Shared constants and slice helper for the buffered N-port crossbar.
// Imported by xbar_out_stage and xbar_nport_buf.
package xbar_pkg;

    localparam int XBAR_NUM_PORT = 5;
    localparam int XBAR_WIDTH    = 64;
    localparam int XBAR_CNT_W    = 8;

    // Low bit of element idx in a flat vector of w-bit elements
    function automatic int slice_lo(input int idx, input int w);
        return idx * w;
    endfunction

endpackage

// File: rtl/xbar_out_stage.sv
// One crossbar output: lowest-index priority pick over its request
// column, free/conflict flags and the single registered flit slot.
module xbar_out_stage
    import xbar_pkg::*;
#(
    parameter int NUM_PORT = XBAR_NUM_PORT,
    parameter int WIDTH    = XBAR_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_PORT-1:0]       i_req,
    input  logic [NUM_PORT-1:0]       i_in_ready,
    input  logic [NUM_PORT*WIDTH-1:0] i_data,
    input  logic                      i_out_ready,
    output logic [NUM_PORT-1:0]       o_grant,
    output logic                      o_free,
    output logic                      o_valid,
    output logic [WIDTH-1:0]          o_data,
    output logic                      o_conflict
);

    logic [NUM_PORT-1:0] w_grant;
    logic                w_load;
    logic [WIDTH-1:0]    w_sel;
    logic                r_valid;
    logic [WIDTH-1:0]    r_data;

    // Isolate the lowest set request bit; any second bit is a conflict
    assign w_grant    = i_req & (~i_req + 1'b1);
    assign o_conflict = |(i_req & (i_req - 1'b1));
    assign o_grant    = w_grant;

    // Slot may refill in the same cycle it drains
    assign o_free = !r_valid || i_out_ready;
    assign w_load = o_free && (|(w_grant & i_in_ready));

    // Select the granted input's flit (grant is one-hot or zero)
    always_comb begin
        w_sel = '0;
        for (int i = 0; i < NUM_PORT; i++) begin
            if (w_grant[i]) begin
                w_sel = i_data[slice_lo(i, WIDTH) +: WIDTH];
            end
        end
    end

    // Output slot: load on grant, clear on drain, hold otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (w_load) begin
            r_valid <= 1'b1;
            r_data  <= w_sel;
        end else if (i_out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/xbar_nport_buf.sv
// N-port buffered crossbar with all-or-nothing multicast.
// Define XBAR_CONFLICT_CNT_EN to add the saturating conflict_cnt port.
module xbar_nport_buf
    import xbar_pkg::*;
#(
    parameter int NUM_PORT = XBAR_NUM_PORT,
    parameter int WIDTH    = XBAR_WIDTH
`ifdef XBAR_CONFLICT_CNT_EN
    ,
    parameter int CNT_W    = XBAR_CNT_W
`endif
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_PORT*NUM_PORT-1:0] alloc_vec,
    input  logic [NUM_PORT-1:0]          in_valid,
    input  logic [NUM_PORT*WIDTH-1:0]    in_data,
    output logic [NUM_PORT-1:0]          in_ready,
    output logic [NUM_PORT-1:0]          out_valid,
    output logic [NUM_PORT*WIDTH-1:0]    out_data,
    input  logic [NUM_PORT-1:0]          out_ready,
    output logic [NUM_PORT-1:0]          conflict,
    output logic [NUM_PORT-1:0]          drop
`ifdef XBAR_CONFLICT_CNT_EN
    ,
    output logic [CNT_W-1:0]             conflict_cnt
`endif
);

    localparam int NN = NUM_PORT * NUM_PORT;

    // Column-major views: [j*N+i] is input i at output j
    logic [NN-1:0]       w_req_col;
    logic [NN-1:0]       w_gnt_col;
    // Row-major grant: [i*N+j]
    logic [NN-1:0]       w_gnt_row;
    logic [NUM_PORT-1:0] w_free;

    for (genvar i = 0; i < NUM_PORT; i++) begin : g_in
        for (genvar j = 0; j < NUM_PORT; j++) begin : g_col
            assign w_req_col[j*NUM_PORT+i] =
                in_valid[i] & alloc_vec[i*NUM_PORT+j];
            assign w_gnt_row[i*NUM_PORT+j] =
                w_gnt_col[j*NUM_PORT+i];
        end

        // Every masked output must be won and free; empty mask drops
        assign in_ready[i] =
            &(~alloc_vec[slice_lo(i, NUM_PORT) +: NUM_PORT] |
              (w_gnt_row[slice_lo(i, NUM_PORT) +: NUM_PORT] & w_free));

        assign drop[i] = in_valid[i] &
            ~|alloc_vec[slice_lo(i, NUM_PORT) +: NUM_PORT];
    end

    for (genvar j = 0; j < NUM_PORT; j++) begin : g_out
        xbar_out_stage #(
            .NUM_PORT (NUM_PORT),
            .WIDTH    (WIDTH)
        ) u_stage (
            .clk        (clk),
            .rst_n      (rst_n),
            .i_req      (w_req_col[slice_lo(j, NUM_PORT) +: NUM_PORT]),
            .i_in_ready (in_ready),
            .i_data     (in_data),
            .i_out_ready(out_ready[j]),
            .o_grant    (w_gnt_col[slice_lo(j, NUM_PORT) +: NUM_PORT]),
            .o_free     (w_free[j]),
            .o_valid    (out_valid[j]),
            .o_data     (out_data[slice_lo(j, WIDTH) +: WIDTH]),
            .o_conflict (conflict[j])
        );
    end

`ifdef XBAR_CONFLICT_CNT_EN
    logic [CNT_W-1:0] r_cnt;

    // Count cycles with any output conflict, sticking at all ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if ((|conflict) && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign conflict_cnt = r_cnt;
`endif

endmodule

// File: tb/tb_xbar_nport_buf.sv
// Self-checking bench for xbar_nport_buf with a per-output scoreboard.
// Build with XBAR_CONFLICT_CNT_EN to also exercise conflict_cnt.
module tb_xbar_nport_buf;

    localparam int N = 5;
    localparam int W = 64;
`ifdef XBAR_CONFLICT_CNT_EN
    localparam int CW = 8;
    logic [CW-1:0] conflict_cnt;
`endif

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N*N-1:0] alloc_vec;
    logic [N-1:0]   in_valid;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_ready;
    logic [N-1:0]   out_valid;
    logic [N*W-1:0] out_data;
    logic [N-1:0]   out_ready;
    logic [N-1:0]   conflict;
    logic [N-1:0]   drop;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] q [N][$];

    int           m_win [N];
    int           m_cnt;
    logic [N-1:0] m_has, m_fr, m_er, m_cf, m_dr, m_m;

    xbar_nport_buf #(
        .NUM_PORT(N),
        .WIDTH   (W)
`ifdef XBAR_CONFLICT_CNT_EN
        ,
        .CNT_W   (CW)
`endif
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .alloc_vec(alloc_vec),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_ready(out_ready),
        .conflict (conflict),
        .drop     (drop)
`ifdef XBAR_CONFLICT_CNT_EN
        ,
        .conflict_cnt(conflict_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model and scoreboard, sampled on the falling edge
    always @(negedge clk) begin
        if (!rst_n) begin
            checks++;
            if (out_valid !== '0) begin
                errors++;
                $display("FAIL mon_rst_valid got %b exp 0", out_valid);
            end
            for (int j = 0; j < N; j++) q[j].delete();
        end else begin
            for (int j = 0; j < N; j++) begin
                m_fr[j] = (q[j].size() == 0) || out_ready[j];
                m_cnt = 0;
                m_has[j] = 1'b0;
                m_win[j] = 0;
                for (int i = 0; i < N; i++) begin
                    if (in_valid[i] && alloc_vec[i*N+j]) begin
                        m_cnt++;
                        if (!m_has[j]) begin
                            m_has[j] = 1'b1;
                            m_win[j] = i;
                        end
                    end
                end
                m_cf[j] = (m_cnt > 1);
            end
            for (int i = 0; i < N; i++) begin
                m_m = alloc_vec[i*N +: N];
                m_dr[i] = in_valid[i] && (m_m == '0);
                m_er[i] = 1'b1;
                for (int j = 0; j < N; j++) begin
                    if (m_m[j] && !(m_has[j] && m_win[j] == i && m_fr[j]))
                        m_er[i] = 1'b0;
                end
            end
            checks++;
            if (conflict !== m_cf) begin
                errors++;
                $display("FAIL mon_conflict got %b exp %b", conflict, m_cf);
            end
            checks++;
            if (drop !== m_dr) begin
                errors++;
                $display("FAIL mon_drop got %b exp %b", drop, m_dr);
            end
            for (int i = 0; i < N; i++) begin
                if (in_valid[i]) begin
                    checks++;
                    if (in_ready[i] !== m_er[i]) begin
                        errors++;
                        $display("FAIL mon_in_ready[%0d] got %b exp %b",
                                 i, in_ready[i], m_er[i]);
                    end
                end
            end
            for (int j = 0; j < N; j++) begin
                checks++;
                if (out_valid[j] !== (q[j].size() != 0)) begin
                    errors++;
                    $display("FAIL mon_out_valid[%0d] got %b exp %b",
                             j, out_valid[j], q[j].size() != 0);
                end else if (q[j].size() != 0) begin
                    checks++;
                    if (out_data[j*W +: W] !== q[j][0]) begin
                        errors++;
                        $display("FAIL mon_out_data[%0d] got %h exp %h",
                                 j, out_data[j*W +: W], q[j][0]);
                    end
                end
            end
            for (int j = 0; j < N; j++) begin
                if (out_ready[j] && q[j].size() != 0) void'(q[j].pop_front());
            end
            for (int i = 0; i < N; i++) begin
                m_m = alloc_vec[i*N +: N];
                if (in_valid[i] && m_er[i] && m_m != '0) begin
                    for (int j = 0; j < N; j++) begin
                        if (m_m[j]) q[j].push_back(in_data[i*W +: W]);
                    end
                end
            end
        end
    end

    task automatic set_in(input int i, input logic v,
                          input logic [N-1:0] m, input logic [W-1:0] d);
        in_valid[i]        = v;
        alloc_vec[i*N +: N] = m;
        in_data[i*W +: W]  = d;
    endtask

    task automatic idle();
        in_valid  = '0;
        alloc_vec = '0;
        in_data   = '0;
        out_ready = '1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        #2;
        checks++;
        if (out_valid !== '0) begin
            errors++;
            $display("FAIL reset_valid got %b exp 0", out_valid);
        end
        checks++;
        if (out_data !== '0) begin
            errors++;
            $display("FAIL reset_data got %h exp 0", out_data);
        end
        checks++;
        if (conflict !== '0 || drop !== '0) begin
            errors++;
            $display("FAIL reset_flags got %b/%b exp 0/0", conflict, drop);
        end
`ifdef XBAR_CONFLICT_CNT_EN
        checks++;
        if (conflict_cnt !== '0) begin
            errors++;
            $display("FAIL reset_cnt got %0d exp 0", conflict_cnt);
        end
`endif
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_permutation();
        logic [W-1:0] d [N];
        int o;
        for (int k = 0; k < N; k++) begin
            for (int i = 0; i < N; i++) begin
                d[i] = 64'h0A00_0000_0000_0000 + 64'((i + 10) * 16 + k);
                o = (i + k) % N;
                set_in(i, 1'b1, N'(1 << o), d[i]);
            end
            #2;
            checks++;
            if (in_ready !== '1) begin
                errors++;
                $display("FAIL perm_rdy k=%0d got %b exp 11111", k, in_ready);
            end
            checks++;
            if (conflict !== '0) begin
                errors++;
                $display("FAIL perm_conf k=%0d got %b exp 0", k, conflict);
            end
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                o = (i + k) % N;
                checks++;
                if (out_data[o*W +: W] !== d[i]) begin
                    errors++;
                    $display("FAIL perm_data k=%0d out%0d got %h exp %h",
                             k, o, out_data[o*W +: W], d[i]);
                end
            end
        end
        idle();
    endtask

    task automatic test_conflict();
        logic [W-1:0] d1, d3;
        d1 = 64'h1111_0000_0000_0001;
        d3 = 64'h3333_0000_0000_0003;
        idle();
        set_in(1, 1'b1, 5'b00100, d1);
        set_in(3, 1'b1, 5'b00100, d3);
        #2;
        checks++;
        if (in_ready[1] !== 1'b1 || in_ready[3] !== 1'b0) begin
            errors++;
            $display("FAIL conf_rdy got %b%b exp 10", in_ready[1], in_ready[3]);
        end
        checks++;
        if (conflict !== 5'b00100) begin
            errors++;
            $display("FAIL conf_flag got %b exp 00100", conflict);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_data[2*W +: W] !== d1) begin
            errors++;
            $display("FAIL conf_first got %h exp %h", out_data[2*W +: W], d1);
        end
        set_in(1, 1'b0, '0, '0);
        #2;
        checks++;
        if (in_ready[3] !== 1'b1) begin
            errors++;
            $display("FAIL conf_rdy3 got %b exp 1", in_ready[3]);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_data[2*W +: W] !== d3) begin
            errors++;
            $display("FAIL conf_second got %h exp %h", out_data[2*W +: W], d3);
        end
        idle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_multicast();
        logic [W-1:0] x, m;
        x = 64'h4444_0000_0000_00AA;
        m = 64'h0000_5555_0000_00BB;
        idle();
        out_ready[4] = 1'b0;
        set_in(2, 1'b1, 5'b10000, x);
        @(posedge clk);
        #1;
        checks++;
        if (out_valid[4] !== 1'b1) begin
            errors++;
            $display("FAIL mc_prefill got %b exp 1", out_valid[4]);
        end
        set_in(2, 1'b0, '0, '0);
        set_in(0, 1'b1, 5'b10110, m);
        #2;
        checks++;
        if (in_ready[0] !== 1'b0) begin
            errors++;
            $display("FAIL mc_stall_rdy got %b exp 0", in_ready[0]);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid[1] !== 1'b0 || out_valid[2] !== 1'b0) begin
            errors++;
            $display("FAIL mc_partial got %b exp 00000", out_valid);
        end
        checks++;
        if (out_data[4*W +: W] !== x) begin
            errors++;
            $display("FAIL mc_hold got %h exp %h", out_data[4*W +: W], x);
        end
        out_ready[4] = 1'b1;
        #2;
        checks++;
        if (in_ready[0] !== 1'b1) begin
            errors++;
            $display("FAIL mc_go_rdy got %b exp 1", in_ready[0]);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 5'b10110) begin
            errors++;
            $display("FAIL mc_valid got %b exp 10110", out_valid);
        end
        checks++;
        if (out_data[1*W +: W] !== m || out_data[2*W +: W] !== m ||
            out_data[4*W +: W] !== m) begin
            errors++;
            $display("FAIL mc_data got %h %h %h exp %h",
                     out_data[1*W +: W], out_data[2*W +: W],
                     out_data[4*W +: W], m);
        end
        idle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure();
        logic [W-1:0] s [4];
        for (int k = 0; k < 4; k++) s[k] = 64'h2200_0000_0000_0000 + 64'(k);
        idle();
        set_in(2, 1'b1, 5'b00001, s[0]);
        @(posedge clk);
        #1;
        checks++;
        if (out_data[W-1:0] !== s[0]) begin
            errors++;
            $display("FAIL bp_first got %h exp %h", out_data[W-1:0], s[0]);
        end
        out_ready[0] = 1'b0;
        set_in(2, 1'b1, 5'b00001, s[1]);
        for (int c = 0; c < 3; c++) begin
            #2;
            checks++;
            if (in_ready[2] !== 1'b0) begin
                errors++;
                $display("FAIL bp_stall_rdy c=%0d got %b exp 0", c, in_ready[2]);
            end
            @(posedge clk);
            #1;
            checks++;
            if (out_data[W-1:0] !== s[0] || out_valid[0] !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold c=%0d got %h/%b exp %h/1",
                         c, out_data[W-1:0], out_valid[0], s[0]);
            end
        end
        out_ready[0] = 1'b1;
        for (int k = 1; k < 4; k++) begin
            set_in(2, 1'b1, 5'b00001, s[k]);
            #2;
            checks++;
            if (in_ready[2] !== 1'b1) begin
                errors++;
                $display("FAIL bp_resume_rdy k=%0d got %b exp 1", k, in_ready[2]);
            end
            @(posedge clk);
            #1;
            checks++;
            if (out_data[W-1:0] !== s[k]) begin
                errors++;
                $display("FAIL bp_stream k=%0d got %h exp %h",
                         k, out_data[W-1:0], s[k]);
            end
        end
        idle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_drop();
        idle();
        set_in(4, 1'b1, 5'b00000, 64'hDEAD_BEEF_0000_0004);
        #2;
        checks++;
        if (drop !== 5'b10000) begin
            errors++;
            $display("FAIL drop_flag got %b exp 10000", drop);
        end
        checks++;
        if (in_ready[4] !== 1'b1) begin
            errors++;
            $display("FAIL drop_rdy got %b exp 1", in_ready[4]);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 5'b00000) begin
            errors++;
            $display("FAIL drop_valid got %b exp 00000", out_valid);
        end
        idle();
    endtask

    task automatic test_reset_mid();
        idle();
        out_ready = '0;
        for (int i = 0; i < N; i++)
            set_in(i, 1'b1, N'(1 << i), 64'h7700_0000_0000_0000 + 64'(i));
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 5'b11111) begin
            errors++;
            $display("FAIL rmid_full got %b exp 11111", out_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== '0 || out_data !== '0) begin
            errors++;
            $display("FAIL rmid_clear got %b/%h exp 0/0", out_valid, out_data);
        end
        idle();
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

`ifdef XBAR_CONFLICT_CNT_EN
    task automatic test_conflict_cnt();
        idle();
        set_in(0, 1'b1, 5'b00001, 64'hC0);
        set_in(1, 1'b1, 5'b00001, 64'hC1);
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (conflict_cnt !== 8'd10) begin
            errors++;
            $display("FAIL cnt_10 got %0d exp 10", conflict_cnt);
        end
        repeat (290) @(posedge clk);
        #1;
        checks++;
        if (conflict_cnt !== 8'd255) begin
            errors++;
            $display("FAIL cnt_sat got %0d exp 255", conflict_cnt);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (conflict_cnt !== 8'd0) begin
            errors++;
            $display("FAIL cnt_rst got %0d exp 0", conflict_cnt);
        end
        idle();
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
        test_permutation();
        test_conflict();
        test_multicast();
        test_backpressure();
        test_drop();
        test_reset_mid();
`ifdef XBAR_CONFLICT_CNT_EN
        test_conflict_cnt();
`endif
        repeat (3) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
